div_result_bcd: RTL and testbench

- Downstream stage of the 8-bit combinational divider.
- Accepts one Quotient/Remainder pair over a valid/ready handshake and converts both to packed BCD, sequentially, using double-dabble (shift-add-3).
- Presents the results to the display/report stage over a second valid/ready handshake.
- Two conversion engines run in parallel, one bit per clock.

---
 rtl/div_result_bcd.sv | 139 +++++++++++++
 tb/tb_div_result_bcd.sv | 229 ++++++++++++++++++++++
 2 files changed

// File: rtl/div_result_bcd.sv
// div_result_bcd: converts one quotient/remainder pair from the divider into
// packed BCD using two parallel double-dabble engines, one bit per clock.
// Ports:
//   clk, rst_n            clock, asynchronous active-low reset
//   in_valid / in_ready   upstream handshake; in_ready is high only in IDLE
//   quotient, remainder   binary operands, sampled only at the accept edge
//   out_valid / out_ready downstream handshake for the finished conversion
//   q_bcd, r_bcd          packed BCD results, digit 0 in bits [3:0]
//   busy                  high while a conversion is in flight or waiting
module div_result_bcd #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned NDIG  = 3
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [WIDTH-1:0]    quotient,
    input  logic [WIDTH-1:0]    remainder,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [4*NDIG-1:0]   q_bcd,
    output logic [4*NDIG-1:0]   r_bcd,
    output logic                busy
);

    localparam int unsigned BW = 4 * NDIG;
    localparam int unsigned CW = $clog2(WIDTH + 1);

    function automatic longint unsigned pow10(input int unsigned n);
        longint unsigned p;
        p = 64'd1;
        for (int unsigned i = 0; i < n; i++) begin
            p = p * 64'd10;
        end
        return p;
    endfunction

    // The largest operand must fit in NDIG decimal digits.
    if (pow10(NDIG) <= ((64'd1 << WIDTH) - 64'd1)) begin : g_illegal_ndig
        $error("div_result_bcd: NDIG too small for WIDTH");
    end

    typedef enum logic [1:0] {
        IDLE,
        SHIFT,
        DONE
    } state_t;

    state_t            state;
    state_t            state_next;
    logic [WIDTH-1:0]  q_bin;
    logic [WIDTH-1:0]  r_bin;
    logic [BW-1:0]     q_acc;
    logic [BW-1:0]     r_acc;
    logic [BW-1:0]     q_adj;
    logic [BW-1:0]     r_adj;
    logic [CW-1:0]     cnt;
    logic              accept;
    logic              release_out;
    logic              shift_done;

    // Add 3 to every digit >= 5 so the following left shift carries correctly.
    function automatic logic [BW-1:0] add3(input logic [BW-1:0] b);
        logic [BW-1:0] r;
        r = b;
        for (int unsigned i = 0; i < NDIG; i++) begin
            if (b[4*i +: 4] >= 4'd5) begin
                r[4*i +: 4] = b[4*i +: 4] + 4'd3;
            end
        end
        return r;
    endfunction

    assign in_ready    = (state == IDLE);
    assign accept      = in_valid && in_ready;
    assign release_out = out_valid && out_ready;
    // All WIDTH bits have been shifted in; this edge loads the result.
    assign shift_done  = (state == SHIFT) && (cnt == CW'(WIDTH));
    assign q_adj       = add3(q_acc);
    assign r_adj       = add3(r_acc);

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic.
    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (accept)      state_next = SHIFT;
            SHIFT:   if (shift_done)  state_next = DONE;
            DONE:    if (release_out) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Conversion datapath and registered outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q_bin     <= '0;
            r_bin     <= '0;
            q_acc     <= '0;
            r_acc     <= '0;
            cnt       <= '0;
            q_bcd     <= '0;
            r_bcd     <= '0;
            out_valid <= 1'b0;
            busy      <= 1'b0;
        end else begin
            out_valid <= (state_next == DONE);
            busy      <= (state_next != IDLE);
            if (accept) begin
                q_bin <= quotient;
                r_bin <= remainder;
                q_acc <= '0;
                r_acc <= '0;
                cnt   <= '0;
            end else if ((state == SHIFT) && !shift_done) begin
                q_acc <= BW'({q_adj, q_bin[WIDTH-1]});
                r_acc <= BW'({r_adj, r_bin[WIDTH-1]});
                q_bin <= WIDTH'({q_bin, 1'b0});
                r_bin <= WIDTH'({r_bin, 1'b0});
                cnt   <= cnt + CW'(1);
            end
            // Results hold after the handshake until the next load.
            if (shift_done) begin
                q_bcd <= q_acc;
                r_bcd <= r_acc;
            end
        end
    end

endmodule

// File: tb/tb_div_result_bcd.sv
// Bench for div_result_bcd: directed scenarios plus randomized pairs, checked
// against a decimal-arithmetic reference.
module tb_div_result_bcd;

    localparam int unsigned WIDTH = 8;
    localparam int unsigned NDIG  = 3;
    localparam int unsigned BW    = 4 * NDIG;
    localparam int unsigned LAT   = WIDTH + 1;
    localparam int unsigned TMO   = 100;

    logic              clk = 1'b0;
    logic              rst_n;
    logic              in_valid;
    logic              in_ready;
    logic [WIDTH-1:0]  quotient;
    logic [WIDTH-1:0]  remainder;
    logic              out_valid;
    logic              out_ready;
    logic [BW-1:0]     q_bcd;
    logic [BW-1:0]     r_bcd;
    logic              busy;

    int n_checks = 0;
    int n_fail   = 0;

    div_result_bcd #(.WIDTH(WIDTH), .NDIG(NDIG)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .quotient  (quotient),
        .remainder (remainder),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .q_bcd     (q_bcd),
        .r_bcd     (r_bcd),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    // Reference: decimal digits by repeated division.
    function automatic logic [BW-1:0] to_bcd(input int unsigned v);
        logic [BW-1:0] r;
        int unsigned   x;
        r = '0;
        x = v;
        for (int i = 0; i < int'(NDIG); i++) begin
            r[4*i +: 4] = 4'(x % 10);
            x = x / 10;
        end
        return r;
    endfunction

    function automatic logic digits_ok(input logic [BW-1:0] b);
        logic ok;
        ok = 1'b1;
        for (int i = 0; i < int'(NDIG); i++) begin
            if (b[4*i +: 4] > 4'd9) ok = 1'b0;
        end
        return ok;
    endfunction

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // One pair end to end; hold = cycles of out_ready=0 after out_valid,
    // churn = scramble inputs every cycle while the conversion runs.
    task automatic xfer(input int unsigned q, input int unsigned r,
                        input int unsigned hold, input bit churn);
        int unsigned   edges;
        logic [BW-1:0] eq;
        logic [BW-1:0] er;
        eq = to_bcd(q);
        er = to_bcd(r);
        @(negedge clk);
        quotient  = WIDTH'(q);
        remainder = WIDTH'(r);
        in_valid  = 1'b1;
        out_ready = (hold == 0);
        check("idle_in_ready", 32'(in_ready), 32'd1);
        @(posedge clk);
        edges = 0;
        @(negedge clk);
        if (!churn) in_valid = 1'b0;
        while (!out_valid && edges < TMO) begin
            check("busy_not_ready", 32'({busy, in_ready}), 32'b10);
            if (churn) begin
                quotient  = WIDTH'($urandom);
                remainder = WIDTH'($urandom);
                in_valid  = 1'($urandom);
            end
            @(posedge clk);
            edges++;
            @(negedge clk);
        end
        in_valid = 1'b0;
        check("latency", 32'(edges), 32'(LAT));
        check("q_bcd", 32'(q_bcd), 32'(eq));
        check("r_bcd", 32'(r_bcd), 32'(er));
        check("digits", 32'({digits_ok(q_bcd), digits_ok(r_bcd)}), 32'b11);
        for (int unsigned h = 0; h < hold; h++) begin
            check("hold_valid", 32'({out_valid, in_ready, busy}), 32'b101);
            check("hold_q", 32'(q_bcd), 32'(eq));
            check("hold_r", 32'(r_bcd), 32'(er));
            @(posedge clk);
            @(negedge clk);
        end
        out_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        check("post_hs_flags", 32'({out_valid, busy, in_ready}), 32'b001);
        check("post_hs_keep", 32'({q_bcd, r_bcd}), 32'({eq, er}));
        out_ready = 1'b0;
    endtask

    // in_valid held high across three pairs with out_ready always high.
    task automatic back_to_back();
        int unsigned qs[3];
        int unsigned rs[3];
        int unsigned acc_cyc[3];
        int unsigned nacc;
        int unsigned nres;
        int unsigned cyc;
        bit          acc;
        qs = '{10, 99, 254};
        rs = '{1, 9, 253};
        nacc = 0;
        nres = 0;
        cyc  = 0;
        @(negedge clk);
        quotient  = WIDTH'(qs[0]);
        remainder = WIDTH'(rs[0]);
        in_valid  = 1'b1;
        out_ready = 1'b1;
        while (nres < 3 && cyc < 200) begin
            if (out_valid) begin
                check("b2b_q", 32'(q_bcd), 32'(to_bcd(qs[nres])));
                check("b2b_r", 32'(r_bcd), 32'(to_bcd(rs[nres])));
                nres++;
            end
            acc = in_valid && in_ready;
            if (acc) begin
                if (nacc < 3) acc_cyc[nacc] = cyc;
                nacc++;
            end
            @(posedge clk);
            cyc++;
            @(negedge clk);
            if (acc) begin
                if (nacc < 3) begin
                    quotient  = WIDTH'(qs[nacc]);
                    remainder = WIDTH'(rs[nacc]);
                end else begin
                    in_valid = 1'b0;
                end
            end
        end
        in_valid  = 1'b0;
        out_ready = 1'b0;
        check("b2b_results", 32'(nres), 32'd3);
        check("b2b_accepts", 32'(nacc), 32'd3);
        if (nacc == 3) begin
            // Accept, LAT edges to out_valid, handshake edge, one IDLE cycle.
            check("b2b_gap1", 32'(acc_cyc[1] - acc_cyc[0]), 32'(LAT + 2));
            check("b2b_gap2", 32'(acc_cyc[2] - acc_cyc[1]), 32'(LAT + 2));
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, n_checks=%0d", n_checks);
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        quotient  = '0;
        remainder = '0;
        repeat (3) @(negedge clk);
        check("rst_outputs", 32'({out_valid, busy, q_bcd, r_bcd}), 32'd0);
        rst_n = 1'b1;
        @(negedge clk);
        check("rst_in_ready", 32'(in_ready), 32'd1);

        xfer(36, 3, 0, 1'b0);
        xfer(255, 0, 0, 1'b0);
        xfer(0, 199, 0, 1'b0);
        xfer(128, 99, 20, 1'b0);
        xfer(57, 6, 0, 1'b1);

        // Abort in the middle of SHIFT.
        @(negedge clk);
        quotient  = WIDTH'(77);
        remainder = WIDTH'(5);
        in_valid  = 1'b1;
        out_ready = 1'b1;
        @(posedge clk);
        #1 in_valid = 1'b0;
        repeat (4) @(posedge clk);
        #1 rst_n = 1'b0;
        #1;
        check("mid_rst_outputs", 32'({out_valid, busy, q_bcd, r_bcd}), 32'd0);
        check("mid_rst_in_ready", 32'(in_ready), 32'd1);
        out_ready = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        xfer(200, 12, 0, 1'b0);

        back_to_back();

        xfer(255, 255, 1, 1'b0);
        for (int i = 0; i < 30; i++) begin
            xfer($urandom_range(0, 255), $urandom_range(0, 255),
                 $urandom_range(0, 3), 1'($urandom));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
